// File: rtl/cr_2_if.sv
// Control, status and display signals of cr_2, grouped for connection as one port.
// The module drives the slave side; the environment drives the master side.
interface cr_2_if #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
);
    logic                     ENgen;
    logic                     ENwrk;
    logic                     ENraf;
    logic [1:0]               mode;
    logic [W-1:0]             thr;
    logic [$clog2(DEPTH):0]   usedw;
    logic                     full;
    logic                     empty;
    logic [CNT_W-1:0]         bc;
    logic                     ovf;
    logic [6:0]               ss;
    logic [3:0]               dig;

    modport master (
        output ENgen, ENwrk, ENraf, mode, thr,
        input  usedw, full, empty, bc, ovf, ss, dig
    );

    modport slave (
        input  ENgen, ENwrk, ENraf, mode, thr,
        output usedw, full, empty, bc, ovf, ss, dig
    );
endinterface

// File: rtl/cr_2.sv
// Counting generator feeding a DEPTH x W FIFO; a filtering reader counts matches,
// and the match count is shown on a 4-digit multiplexed active-low hex display.
module cr_2 #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16,
    parameter int DIV   = 1000
) (
    input logic  CLK,
    input logic  RST,
    cr_2_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [W-1:0]     gen_cnt;
    logic [W-1:0]     q;
    logic             q_valid;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      usedw;
    logic [AW:0]      usedw_n;
    logic             full;
    logic             empty;
    logic             wrreq;
    logic             rdreq;
    logic             match;
    logic [CNT_W-1:0] bc;
    logic             ovf;
    logic [RW-1:0]    refresh;
    logic [1:0]       idx;
    logic [1:0]       idx_n;
    logic [15:0]      bc16;
    logic [3:0]       nib;
    logic [6:0]       ss;
    logic [3:0]       dig;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign wrreq = bus.ENgen & bus.ENwrk & ~full;
    assign rdreq = bus.ENraf & bus.ENwrk & ~empty;

    always_comb begin
        usedw_n = usedw;
        if (wrreq && !rdreq)
            usedw_n = usedw + (AW+1)'(1);
        else if (!wrreq && rdreq)
            usedw_n = usedw - (AW+1)'(1);
    end

    always_comb begin
        match = 1'b0;
        case (bus.mode)
            2'd0:    match = 1'b1;
            2'd1:    match = ~q[0];
            2'd2:    match = (q > bus.thr);
            default: match = (q == bus.thr);
        endcase
    end

    // dig and ss are both loaded from the next digit index so they switch together.
    always_comb begin
        idx_n = (refresh == RW'(DIV - 1)) ? idx + 2'd1 : idx;
        bc16  = 16'(bc);
        nib   = bc16[{idx_n, 2'b00} +: 4];
    end

    always_ff @(posedge CLK) begin
        if (wrreq)
            mem[wr_ptr] <= gen_cnt;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            gen_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            usedw   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            q       <= '0;
            q_valid <= 1'b0;
            bc      <= '0;
            ovf     <= 1'b0;
            refresh <= '0;
            idx     <= '0;
            dig     <= 4'b1110;
            ss      <= 7'b1000000;
        end else begin
            if (wrreq) begin
                gen_cnt <= gen_cnt + W'(1);
                wr_ptr  <= wr_ptr + AW'(1);
            end
            if (rdreq) begin
                q      <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            q_valid <= rdreq;
            usedw   <= usedw_n;
            full    <= (usedw_n == (AW+1)'(DEPTH));
            empty   <= (usedw_n == '0);

            // A pending evaluation completes even if the enables drop meanwhile.
            if (q_valid && match) begin
                if (bc == '1)
                    ovf <= 1'b1;
                else
                    bc <= bc + CNT_W'(1);
            end

            refresh <= (refresh == RW'(DIV - 1)) ? '0 : refresh + RW'(1);
            idx     <= idx_n;
            dig     <= ~(4'b0001 << idx_n);
            ss      <= hex7(nib);
        end
    end

    assign bus.usedw = usedw;
    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.bc    = bc;
    assign bus.ovf   = ovf;
    assign bus.ss    = ss;
    assign bus.dig   = dig;
endmodule

// File: doc/cr_2.md
Name: cr_2

Overview:
- Parametrised successor of the generator -> FIFO -> read-and-filter -> 7-segment chain, built as one block.
- A counting generator fills an internal DEPTH x W FIFO.
- A reader drains the FIFO and counts words that match a run-time selectable filter mode.
- The match count is shown on a 4-digit multiplexed hex display. Adds width/depth/counter parametrisation, filter modes, saturation flag and full-range usedw.

Parameters:
W, 8, data word width (>=4)
DEPTH, 16, FIFO depth in words; power of two, >=2
CNT_W, 16, match counter width (>=4)
DIV, 1000, CLK cycles each display digit stays active (>=1)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  asynchronous active-low reset
ENgen  in  1  generator enable
ENwrk  in  1  global work enable; low freezes generator and reader
ENraf  in  1  reader enable
mode  in  2  filter: 0 all, 1 even, 2 value>thr, 3 value==thr
thr  in  W  filter threshold (unsigned)
usedw  out  $clog2(DEPTH)+1  FIFO occupancy 0..DEPTH
full  out  1  FIFO full
empty  out  1  FIFO empty
bc  out  CNT_W  match count
ovf  out  1  sticky: a match occurred while bc was saturated
ss  out  7  segments {g,f,e,d,c,b,a}, active-low
dig  out  4  digit select dig[4:1], active-low one-hot

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST. While RST=0:
  - gen counter=0, FIFO pointers=0, usedw=0, full=0, empty=1;
  - bc=0, ovf=0, q_valid=0, refresh counter=0;
  - dig=4'b1110, ss=7'b1000000 (glyph "0").
  - Asserting reset mid-operation discards FIFO contents and any pending read.
- Generator:
  - wrreq = ENgen & ENwrk & ~full (full as registered).
  - On wrreq the word gen_cnt is written and gen_cnt increments modulo 2^W. Sequence is 0,1,2,...
  - gen_cnt holds when no write occurs.
- FIFO:
  - Circular buffer; pointers wrap modulo DEPTH.
  - Writes are ignored when full; reads are ignored when empty.
  - Simultaneous accepted write and read: usedw unchanged, both pointers advance.
  - usedw reaches DEPTH (no wrap to 0). full = (usedw==DEPTH), empty = (usedw==0); both registered and updated in the same cycle as usedw.
- Reader:
  - rdreq = ENraf & ENwrk & ~empty.
  - Read data q is registered: valid the cycle after rdreq (q_valid). Latency from write to bc update is at least 3 cycles.
  - When q_valid is set, the filter is evaluated on q with the current mode/thr:
    - mode 0: always matches;
    - mode 1: matches when q[0]==0;
    - mode 2: matches when q>thr;
    - mode 3: matches when q==thr.
  - On a match: bc+1, saturating at all-ones. A match arriving while bc is all-ones sets ovf; ovf is cleared only by reset.
  - Dropping ENwrk or ENraf after a read completes that pending q_valid evaluation.
- Display:
  - The refresh counter counts 0..DIV-1, then advances the digit index 0->1->2->3->0.
  - Digit index i drives dig[i+1]=0 and shows the hex nibble bc[4i+3:4i]. Missing bits when CNT_W<16 read as 0.
  - ss is the standard active-low hex decode for 0-F, registered with dig so both change in the same cycle.

Test Plan:
- Fill: DEPTH=16, ENgen=ENwrk=1, ENraf=0 for 20 cycles -> full=1 and usedw=16 after 16 writes; gen_cnt stays 16; FIFO holds 0..15.
- Drain, mode 0: after fill, ENgen=0, ENraf=1 -> 16 reads, empty=1, usedw=0, bc=16 three cycles after the last rdreq; no further rdreq.
- Filter modes: refill 0..15 and drain each time, reset between runs. mode=1 -> bc=8; mode=2, thr=10 -> bc=5; mode=3, thr=7 -> bc=1.
- Streaming: ENgen=ENraf=ENwrk=1 for 100 cycles, mode 0 -> usedw settles at 0/1 with no overflow or underflow; bc equals the number of accepted writes minus usedw minus pending reads; a pulse of ENwrk=0 freezes gen_cnt and bc.
- Saturation: CNT_W=4, mode 0, 20 words -> bc=15, ovf=1 from the 16th match; RST low mid-stream -> bc=0, ovf=0, usedw=0 immediately (asynchronous, no clock edge needed).
- Display: DIV=4, bc forced to 0x1234 -> dig sequence 1110,1101,1011,0111 changing every 4 cycles; ss shows 4,3,2,1 respectively (7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001).
